// File: rtl/pet_stats_engine.sv
// pet_stats_engine
//   NUM_STATS saturating stat counters with a self-timed decay tick, a
//   valid/ready command port, and sleep/death tracking.
//
//   Optional build macro: AUTO_WAKE_EN. When it is defined, a sleeping pet
//   wakes at the end of any decay scan in which energy reaches the maximum.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   rand_in      free-running random byte (bits [7:6] drive extra decay)
//   cmd_valid    command present
//   cmd_ready    command accepted on this cycle if cmd_valid is also high
//   cmd_op       00 add, 01 sub, 10 set, 11 sleep toggle
//   cmd_idx      target channel (out-of-range index writes nothing)
//   cmd_amt      operand
//   stats_flat   channel i at [i*STAT_W +: STAT_W]
//   low_flags    registered, bit i = stat_i < LOW_THRESH
//   sleeping     pet asleep
//   alive        drops to 0 once dead, held until reset
//   tick         one-cycle pulse per decay tick

// One stat channel: its value register and its registered low flag.
module pet_stat_lane #(
  parameter int STAT_W     = 5,
  parameter int LOW_THRESH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [STAT_W-1:0] wr_val,
  output logic [STAT_W-1:0] stat,
  output logic              low
);
  logic [STAT_W-1:0] stat_q;
  logic              low_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= '1;
      low_q  <= 1'b0;
    end else begin
      if (wr_en) stat_q <= wr_val;
      // Follows the stored value, so it lags any write by one cycle.
      low_q <= (int'(stat_q) < LOW_THRESH);
    end
  end

  assign stat = stat_q;
  assign low  = low_q;
endmodule

module pet_stats_engine #(
  parameter int NUM_STATS   = 6,
  parameter int STAT_W      = 5,
  parameter int TICK_DIV    = 10_000_000,
  parameter int LOW_THRESH  = 4,
  parameter int DEATH_TICKS = 8,
  parameter int HEALTH_IDX  = 2,
  parameter int ENERGY_IDX  = 4,
  localparam int IDX_W = (NUM_STATS <= 2) ? 1 : $clog2(NUM_STATS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  rand_in,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_op,
  input  logic [IDX_W-1:0]            cmd_idx,
  input  logic [STAT_W-1:0]           cmd_amt,
  output logic [NUM_STATS*STAT_W-1:0] stats_flat,
  output logic [NUM_STATS-1:0]        low_flags,
  output logic                        sleeping,
  output logic                        alive,
  output logic                        tick
);
  localparam int CNT_W = (TICK_DIV <= 2) ? 1 : $clog2(TICK_DIV);
  localparam int ZC_W  = $clog2(DEATH_TICKS + 1);
  localparam logic [STAT_W:0] MAXV = {1'b0, {STAT_W{1'b1}}};

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_SLP = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_DECAY, S_DEAD} state_e;

  typedef struct packed {
    logic [1:0]        op;
    logic [IDX_W-1:0]  idx;
    logic [STAT_W-1:0] amt;
  } cmd_t;

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [IDX_W-1:0]  scan_q, scan_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [ZC_W-1:0]   zc_q, zc_d;
  logic              tick_q, par_q, pend_q, pend_clr;
  logic              sleep_q, sleep_d, alive_q, alive_d;
`ifdef AUTO_WAKE_EN
  logic              wake_q, wake_d;
`endif

  logic [NUM_STATS-1:0][STAT_W-1:0] stat_w;
  logic [NUM_STATS-1:0]             low_w, wr_en;
  logic [IDX_W-1:0]                 sel;
  logic [STAT_W-1:0]                cur, health_post;
  logic [STAT_W:0]                  cur_w, dlt, sum, res;
  logic                             up, tick_evt, last_scan;
  logic                             unused_rand;

  assign unused_rand = ^rand_in[5:0];

  // ---------------- channel lanes ----------------
  for (genvar g = 0; g < NUM_STATS; g++) begin : g_lane
    pet_stat_lane #(.STAT_W(STAT_W), .LOW_THRESH(LOW_THRESH)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (wr_en[g]),
      .wr_val (res[STAT_W-1:0]),
      .stat   (stat_w[g]),
      .low    (low_w[g])
    );
  end

  // ---------------- prescaler ----------------
  assign tick_evt = (cnt_q == CNT_W'(TICK_DIV - 1));

  // ---------------- shared datapath ----------------
  // Only one channel is ever written per cycle (APPLY target or the scan
  // index), so one saturating add/sub unit serves all lanes.
  assign sel       = (state_q == S_APPLY) ? cmd_q.idx : scan_q;
  assign last_scan = (scan_q == IDX_W'(NUM_STATS - 1));

  always_comb begin
    cur = '0;
    for (int i = 0; i < NUM_STATS; i++)
      if (sel == IDX_W'(i)) cur = stat_w[i];
  end

  always_comb begin
    cur_w = {1'b0, cur};
    up    = 1'b0;
    dlt   = '0;
    if (state_q == S_APPLY) begin
      up  = (cmd_q.op == OP_ADD);
      dlt = {1'b0, cmd_q.amt};
    end else if (sleep_q) begin
      if (scan_q == IDX_W'(ENERGY_IDX)) begin
        up  = 1'b1;
        dlt = (STAT_W+1)'(2);
      end else begin
        // Asleep, other channels only lose a point on every other tick.
        dlt = {{STAT_W{1'b0}}, par_q};
      end
    end else begin
      dlt = (rand_in[7:6] == 2'b11) ? (STAT_W+1)'(2) : (STAT_W+1)'(1);
    end
    sum = cur_w + dlt;   // cannot overflow STAT_W+1 bits
    if (up)               res = (sum > MAXV) ? MAXV : sum;
    else if (dlt > cur_w) res = '0;
    else                  res = cur_w - dlt;
    if ((state_q == S_APPLY) && (cmd_q.op == OP_SET)) res = {1'b0, cmd_q.amt};
  end

  always_comb begin
    for (int i = 0; i < NUM_STATS; i++)
      wr_en[i] = ((state_q == S_APPLY) && (cmd_q.op != OP_SLP) && (cmd_q.idx == IDX_W'(i)))
              || ((state_q == S_DECAY) && (scan_q == IDX_W'(i)));
  end

  // Health as it will be after this cycle's write, for the end-of-scan check.
  assign health_post = (scan_q == IDX_W'(HEALTH_IDX)) ? res[STAT_W-1:0] : stat_w[HEALTH_IDX];

  assign cmd_ready = (state_q == S_IDLE) & ~pend_q & alive_q;

  // ---------------- control FSM ----------------
  always_comb begin
    state_d  = state_q;
    scan_d   = scan_q;
    cmd_d    = cmd_q;
    zc_d     = zc_q;
    sleep_d  = sleep_q;
    alive_d  = alive_q;
    pend_clr = 1'b0;
`ifdef AUTO_WAKE_EN
    wake_d   = wake_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        // Pending decay wins over a waiting command.
        if (pend_q) begin
          state_d  = S_DECAY;
          scan_d   = '0;
          pend_clr = 1'b1;
`ifdef AUTO_WAKE_EN
          wake_d   = 1'b0;
`endif
        end else if (cmd_valid && cmd_ready) begin
          cmd_d.op  = cmd_op;
          cmd_d.idx = cmd_idx;
          cmd_d.amt = cmd_amt;
          state_d   = S_APPLY;
        end
      end
      S_APPLY: begin
        if (cmd_q.op == OP_SLP) sleep_d = ~sleep_q;
        state_d = S_IDLE;
      end
      S_DECAY: begin
`ifdef AUTO_WAKE_EN
        if (sleep_q && (scan_q == IDX_W'(ENERGY_IDX)) && (res == MAXV)) wake_d = 1'b1;
`endif
        if (last_scan) begin
`ifdef AUTO_WAKE_EN
          if (wake_d) sleep_d = 1'b0;
`endif
          state_d = S_IDLE;
          if (health_post == '0) begin
            zc_d = zc_q + ZC_W'(1);
            if (zc_d == ZC_W'(DEATH_TICKS)) begin
              alive_d = 1'b0;
              state_d = S_DEAD;
            end
          end else begin
            zc_d = '0;
          end
        end else begin
          scan_d = scan_q + IDX_W'(1);
        end
      end
      S_DEAD:  state_d = S_DEAD;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      scan_q  <= '0;
      cmd_q   <= '0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      par_q   <= 1'b0;
      pend_q  <= 1'b0;
      zc_q    <= '0;
      sleep_q <= 1'b0;
      alive_q <= 1'b1;
`ifdef AUTO_WAKE_EN
      wake_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      scan_q  <= scan_d;
      cmd_q   <= cmd_d;
      cnt_q   <= tick_evt ? '0 : cnt_q + CNT_W'(1);
      tick_q  <= tick_evt;
      par_q   <= par_q ^ tick_evt;
      // A fresh tick outranks the clear; a tick on top of pending is lost.
      pend_q  <= tick_evt | (pend_q & ~pend_clr);
      zc_q    <= zc_d;
      sleep_q <= sleep_d;
      alive_q <= alive_d;
`ifdef AUTO_WAKE_EN
      wake_q  <= wake_d;
`endif
    end
  end

  assign stats_flat = stat_w;
  assign low_flags  = low_w;
  assign sleeping   = sleep_q;
  assign alive      = alive_q;
  assign tick       = tick_q;
endmodule
